// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the parametrised SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, DONE} state_e;

  function automatic int calc_beats(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  // Counter width that stays at least one bit even for a count of 0 or 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // BYTE_SHIFT = log2(DATA_W/8); evaluated per instance since DATA_W is a parameter.
  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sram_ctrl_param_if.sv
// CPU memory-stage request bus. The be lane mask exists only when
// SRAM_BYTE_EN_EN is defined.
interface sram_ctrl_param_if #(parameter int DATA_W = 32);
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
`ifdef SRAM_BYTE_EN_EN
  logic [DATA_W/8-1:0] be;

  modport master (output wr_en, rd_en, addr, wdata, be, input rdata, ready);
  modport slave  (input wr_en, rd_en, addr, wdata, be, output rdata, ready);
`else
  modport master (output wr_en, rd_en, addr, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, ready);
`endif
endinterface

// File: rtl/sram_addr_map.sv
// CPU byte address -> CPU word index, and word/beat -> SRAM word address.
// Pure combinational; the SRAM address wraps at SRAM_ADDR_W bits.
module sram_addr_map
  import sram_ctrl_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_DQ_W   = 16,
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          BEAT_W      = 1
) (
  input  logic [31:0]            addr,
  input  logic [31:0]            word_in,
  input  logic [BEAT_W-1:0]      beat,
  output logic [31:0]            word,
  output logic [SRAM_ADDR_W-1:0] sram_addr
);
  localparam int BEATS      = calc_beats(DATA_W, SRAM_DQ_W);
  localparam int BYTE_SHIFT = byte_shift(DATA_W);

  logic [31:0] off;

  assign off       = addr - BASE_ADDR;
  assign word      = off >> BYTE_SHIFT;
  assign sram_addr = SRAM_ADDR_W'(word_in * 32'(BEATS) + 32'(beat));
endmodule

// File: rtl/sram_ctrl_param.sv
// CPU-to-async-SRAM controller: splits each DATA_W access into SRAM_DQ_W beats
// with registered pins and a recovery gap. Optional macro: SRAM_BYTE_EN_EN.
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_DQ_W   = 16,
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_ctrl_param_if.slave       bus,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);
  localparam int BEATS  = calc_beats(DATA_W, SRAM_DQ_W);
  localparam int BEAT_W = cnt_w(BEATS);
  localparam int WAIT_W = cnt_w(WAIT_CYCLES);
  localparam int LANES  = SRAM_DQ_W / 8;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   op_wr_q, op_wr_d;
  logic [31:0]            word_q, word_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic                   we_n_q, we_n_d;
  logic                   ub_n_q, ub_n_d;
  logic                   lb_n_q, lb_n_d;
  logic                   dq_oe_q, dq_oe_d;
  logic [SRAM_DQ_W-1:0]   dq_out_q, dq_out_d;
`ifdef SRAM_BYTE_EN_EN
  logic [DATA_W/8-1:0]    be_q, be_d, nxt_be;
`endif

  logic                   ready_c;
  logic                   load_beat;
  logic                   nxt_wr;
  logic [BEAT_W-1:0]      nxt_beat;
  logic [DATA_W-1:0]      nxt_wdata;
  logic [31:0]            map_word, word_new;
  logic [SRAM_ADDR_W-1:0] map_addr;
  logic [LANES-1:0]       lane_en;

  sram_addr_map #(
    .DATA_W(DATA_W), .SRAM_DQ_W(SRAM_DQ_W), .SRAM_ADDR_W(SRAM_ADDR_W),
    .BASE_ADDR(BASE_ADDR), .BEAT_W(BEAT_W)
  ) u_map (
    .addr(bus.addr), .word_in(map_word), .beat(nxt_beat),
    .word(word_new), .sram_addr(map_addr)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    ub_n_d      = 1'b0;
    lb_n_d      = 1'b0;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    ready_c     = 1'b0;
    load_beat   = 1'b0;
    nxt_wr      = op_wr_q;
    nxt_wdata   = wdata_q;
    nxt_beat    = beat_q + 1'b1;
    map_word    = word_q;
`ifdef SRAM_BYTE_EN_EN
    be_d        = be_q;
    nxt_be      = be_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready_c  = ~(bus.wr_en | bus.rd_en);
        nxt_beat = '0;
        map_word = word_new;
        if (bus.wr_en | bus.rd_en) begin
          // Write wins when both requests are raised together.
          load_beat = 1'b1;
          nxt_wr    = bus.wr_en;
          nxt_wdata = bus.wdata;
          op_wr_d   = bus.wr_en;
          word_d    = word_new;
          wdata_d   = bus.wdata;
          beat_d    = '0;
          state_d   = ACCESS;
`ifdef SRAM_BYTE_EN_EN
          nxt_be    = bus.be;
          be_d      = bus.be;
`endif
        end
      end
      ACCESS: begin
        if (!op_wr_q) rdata_d[int'(beat_q)*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          wait_d  = '0;
          state_d = (WAIT_CYCLES == 0) ? DONE : RECOVER;
        end else begin
          beat_d    = beat_q + 1'b1;
          load_beat = 1'b1;
        end
      end
      RECOVER: begin
        if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) state_d = DONE;
        else wait_d = wait_q + 1'b1;
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    lane_en = '1;
`ifdef SRAM_BYTE_EN_EN
    lane_en = nxt_be[int'(nxt_beat)*LANES +: LANES];
`endif
    // Pins are registered, so the beat about to start is set up one edge early.
    if (load_beat) begin
      sram_addr_d = map_addr;
      if (nxt_wr) begin
        dq_out_d = nxt_wdata[int'(nxt_beat)*SRAM_DQ_W +: SRAM_DQ_W];
        we_n_d   = ~|lane_en;
        dq_oe_d  = |lane_en;
        if (SRAM_DQ_W == 16) begin
          lb_n_d = ~lane_en[0];
          ub_n_d = ~lane_en[LANES-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b0;
      lb_n_q      <= 1'b0;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
`ifdef SRAM_BYTE_EN_EN
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
`ifdef SRAM_BYTE_EN_EN
      be_q        <= be_d;
`endif
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DQ_W{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign bus.ready = ready_c;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_sram_ctrl_param.sv
// Scoreboard bench: two controllers (WAIT_CYCLES=2 and 0) on behavioural SRAMs.
module tb_sram_ctrl_param;
  localparam int AW = 18;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_param_if #(.DATA_W(32)) bus0 ();
  sram_ctrl_param_if #(.DATA_W(32)) bus1 ();

  wire  [15:0]   dq0, dq1;
  logic [AW-1:0] a0, a1;
  logic ub0, lb0, we0, ce0, oe0;
  logic ub1, lb1, we1, ce1, oe1;

  sram_ctrl_param #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(a0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
  );
  sram_ctrl_param #(.WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(a1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  // Behavioural SRAMs: drive the bus while WE_N is high, byte-masked write at clock edge.
  logic [15:0] mem0 [0:(1<<AW)-1];
  logic [15:0] mem1 [0:(1<<AW)-1];
  assign dq0 = we0 ? mem0[a0] : 16'hzzzz;
  assign dq1 = we1 ? mem1[a1] : 16'hzzzz;
  always @(posedge clk) begin
    if (!we0) begin
      if (!lb0) mem0[a0][7:0]  <= dq0[7:0];
      if (!ub0) mem0[a0][15:8] <= dq0[15:8];
    end
  end

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   we_lo0 = 0;
  logic last_ub0 = 1'b0;
  logic last_lb0 = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin : we_mon
    forever begin
      @(negedge clk);
      if (!we0) begin
        we_lo0++;
        last_ub0 = ub0;
        last_lb0 = lb0;
      end
    end
  end

  // Completion = request held and ready high.
  initial begin : mon
    int   lat0, lat1;
    exp_t e;
    lat0 = 0;
    lat1 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat0 = 0;
        lat1 = 0;
      end else begin
        if (bus0.wr_en | bus0.rd_en) begin
          if (!bus0.ready) lat0++;
          else begin
            if (q0.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL mon0: unexpected completion, got rdata 0x%0h, required none", bus0.rdata);
            end else begin
              e = q0.pop_front();
              chk({e.name, " rdata"}, 64'(bus0.rdata), 64'(e.rdata));
              chk({e.name, " stall cycles"}, 64'(lat0), 64'(e.lat));
            end
            lat0 = 0;
          end
        end
        if (bus1.wr_en | bus1.rd_en) begin
          if (!bus1.ready) lat1++;
          else begin
            if (q1.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL mon1: unexpected completion, got rdata 0x%0h, required none", bus1.rdata);
            end else begin
              e = q1.pop_front();
              chk({e.name, " rdata"}, 64'(bus1.rdata), 64'(e.rdata));
              chk({e.name, " stall cycles"}, 64'(lat1), 64'(e.lat));
            end
            lat1 = 0;
          end
        end
      end
    end
  end

  task automatic acc0(input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input string nm);
    q0.push_back('{exp_rd, 5, nm});
    @(posedge clk); #1;
    bus0.wr_en = wr; bus0.rd_en = rd; bus0.addr = a; bus0.wdata = wd;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus0.ready) break;
    end
    chk({nm, " completes"}, 64'(bus0.ready), 64'd1);
    @(posedge clk); #1;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
  endtask

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          w;
    logic [AW-1:0] s0, s1;
    for (int i = 0; i < (1<<AW); i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    mem1[6] = 16'hCAFE;
    mem1[7] = 16'hF00D;
    bus0.wr_en = 0; bus0.rd_en = 0; bus0.addr = 0; bus0.wdata = 0;
    bus1.wr_en = 0; bus1.rd_en = 0; bus1.addr = 0; bus1.wdata = 0;
`ifdef SRAM_BYTE_EN_EN
    bus0.be = '1; bus1.be = '1;
`endif
    rst = 1'b1;
    #1;
    chk("reset we_n", 64'(we0), 64'd1);
    chk("reset ready", 64'(bus0.ready), 64'd1);
    chk("reset rdata", 64'(bus0.rdata), 64'd0);
    chk("reset sram_addr", 64'(a0), 64'd0);
    chk("reset ce/oe/ub/lb", 64'({ce0, oe0, ub0, lb0}), 64'd0);
    chk("reset dut1 pins", 64'({we1, ce1, oe1, ub1, lb1}), 64'h10);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Write splits low half first
    w = we_lo0;
    acc0(1, 0, 32'h408, 32'hDEADBEEF, 32'h0, "t1 write");
    chk("t1 sram[4]", 64'(mem0[4]), 64'hBEEF);
    chk("t1 sram[5]", 64'(mem0[5]), 64'hDEAD);
    chk("t1 we_n low cycles", 64'(we_lo0 - w), 64'd2);
    chk("t1 ub/lb", 64'({last_ub0, last_lb0}), 64'd0);

    w = we_lo0;
    acc0(0, 1, 32'h408, 32'h0, 32'hDEADBEEF, "t2 read");
    chk("t2 we_n low cycles", 64'(we_lo0 - w), 64'd0);

    acc0(1, 1, 32'h400, 32'h12345678, 32'hDEADBEEF, "t3 wr+rd");
    chk("t3 sram[0]", 64'(mem0[0]), 64'h5678);
    chk("t3 sram[1]", 64'(mem0[1]), 64'h1234);

    // Below BASE_ADDR wraps to the top of the SRAM
    acc0(1, 0, 32'h3FC, 32'hA5A55A5A, 32'hDEADBEEF, "wrap write");
    chk("wrap sram[3fffe]", 64'(mem0[18'h3FFFE]), 64'h5A5A);
    chk("wrap sram[3ffff]", 64'(mem0[18'h3FFFF]), 64'hA5A5);

    acc0(0, 1, 32'h400, 32'h0, 32'h12345678, "read 0x400");
    acc0(0, 1, 32'h40B, 32'h0, 32'hDEADBEEF, "unaligned read");

    // WAIT_CYCLES=0 instance
    q1.push_back('{32'hF00DCAFE, 3, "t5 read"});
    s0 = '0; s1 = '0;
    @(posedge clk); #1;
    bus1.rd_en = 1'b1; bus1.addr = 32'h40C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) s0 = a1;
      if (i == 2) s1 = a1;
      if (bus1.ready) break;
    end
    chk("t5 completes", 64'(bus1.ready), 64'd1);
    chk("t5 sram_addr beat0", 64'(s0), 64'd6);
    chk("t5 sram_addr beat1", 64'(s1), 64'd7);
    @(posedge clk); #1;
    bus1.rd_en = 1'b0;

    // Reset in the middle of write beat 0
    @(posedge clk); #1;
    bus0.wr_en = 1'b1; bus0.addr = 32'h408; bus0.wdata = 32'h11112222;
    @(posedge clk); #1;
    chk("t4 we_n in beat0", 64'(we0), 64'd0);
    #2;
    rst = 1'b1;
    bus0.wr_en = 1'b0;
    #1;
    chk("t4 we_n async", 64'(we0), 64'd1);
    chk("t4 ready idle", 64'(bus0.ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t4 sram[5]", 64'(mem0[5]), 64'hDEAD);
    chk("t4 rdata cleared", 64'(bus0.rdata), 64'd0);

`ifdef SRAM_BYTE_EN_EN
    w = we_lo0;
    bus0.be = 4'b0100;
    acc0(1, 0, 32'h408, 32'h00AA0000, 32'h0, "t6 byte write");
    bus0.be = '1;
    chk("t6 we_n low cycles", 64'(we_lo0 - w), 64'd1);
    chk("t6 ub/lb", 64'({last_ub0, last_lb0}), 64'b10);
    chk("t6 sram[5]", 64'(mem0[5]), 64'hDEAA);
    chk("t6 sram[4]", 64'(mem0[4]), 64'hBEEF);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("q0 drained", 64'(q0.size()), 64'd0);
    chk("q1 drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
